// File: rtl/interposer_pkg.sv
// Shared definitions for the multipoint interposer arbiter and its per-node stages.
// Holds node/destination/length widths, the request and control slice layouts,
// the injector state encoding and the packed descriptor payload.
package interposer_pkg;

  localparam int unsigned NODE_COUNT = 8;
  localparam int unsigned DEST_W     = 3;
  localparam int unsigned LEN_W      = 4;

  // Request slice per node: {on, dest}; the ON bit is the MSB.
  localparam int unsigned REQ_W      = DEST_W + 1;
  localparam int unsigned REQ_ON_BIT = DEST_W;

  // Control slice per node: {send, receive, bypass}.
  localparam int unsigned CTRL_W      = 3;
  localparam int unsigned CTRL_SEND   = 2;
  localparam int unsigned CTRL_RECV   = 1;
  localparam int unsigned CTRL_BYPASS = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XMIT = 2'd2
  } inj_state_e;

  // Packet descriptor as stored in the injector FIFO; len holds beats-1.
  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [LEN_W-1:0]  len;
  } desc_t;

endpackage

// File: rtl/desc_fifo.sv
// Synchronous descriptor FIFO with registered occupancy and full/empty flags.
// Ports: clk, reset (sync active-low), push/wdata (ignored when full),
// pop/rdata (ignored when empty, rdata is the current head), count, full, empty.
module desc_fifo #(
  parameter int unsigned W     = 7,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("desc_fifo: DEPTH must be a power of 2 and at least 2");
  end
  if (CNT_W != $clog2(DEPTH) + 1) begin : g_bad_cnt_w
    $error("desc_fifo: CNT_W must be clog2(DEPTH)+1");
  end

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Occupancy update; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count;
    case ({do_push, do_pop})
      2'b10:   count_d = count + CNT_W'(1);
      2'b01:   count_d = count - CNT_W'(1);
      default: count_d = count;
    endcase
  end

  // Pointers and flags; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_d;
      full  <= (count_d == CNT_W'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  // Storage array, no reset needed: contents are only read when occupancy says valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/node_request_injector.sv
// Per-node upstream stage for the interposer arbiter.
// Queues packet descriptors, presents the head as the request slice {on, dest},
// pops on the node's Tx grant and sequences the transmit beats.
// Ports: clk, reset (sync active-low), enq_valid/enq_ready/enq_dest/enq_len (push side),
// tx_grant (arbiter send bit), req_out (request slice), xmit_active/xmit_dest/xmit_last
// (beat sequencing), drop_err (self-addressed push rejected), fifo_count (occupancy).
module node_request_injector #(
  parameter int unsigned NODE_ID    = 0,
  parameter int unsigned NODE_COUNT = 8,
  parameter int unsigned DEST_W     = 3,
  parameter int unsigned LEN_W      = 4,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [DEST_W-1:0] enq_dest,
  input  logic [LEN_W-1:0]  enq_len,
  input  logic              tx_grant,
  output logic [DEST_W:0]   req_out,
  output logic              xmit_active,
  output logic [DEST_W-1:0] xmit_dest,
  output logic              xmit_last,
  output logic              drop_err,
  output logic [CNT_W-1:0]  fifo_count
);

  import interposer_pkg::*;

  localparam int unsigned FIFO_W = DEST_W + LEN_W;

  if (DEST_W != $clog2(NODE_COUNT)) begin : g_bad_dest_w
    $error("node_request_injector: DEST_W must be clog2(NODE_COUNT)");
  end
  if (NODE_ID >= NODE_COUNT) begin : g_bad_node_id
    $error("node_request_injector: NODE_ID out of range");
  end

  inj_state_e        state_q;
  inj_state_e        state_d;
  logic [LEN_W-1:0]  beat_q;
  logic [LEN_W-1:0]  beat_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic [FIFO_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DEST_W-1:0] head_dest;
  logic [LEN_W-1:0]  head_len;
  logic              self_addr;

  logic [DEST_W:0]   req_d;
  logic              xmit_active_d;
  logic [DEST_W-1:0] xmit_dest_d;
  logic              xmit_last_d;
  logic              drop_d;

  assign self_addr = (enq_dest == DEST_W'(NODE_ID));
  assign fifo_push = enq_valid && !fifo_full && !self_addr;
  assign head_dest = fifo_rdata[FIFO_W-1 -: DEST_W];
  assign head_len  = fifo_rdata[LEN_W-1:0];
  assign enq_ready = !fifo_full;

  desc_fifo #(
    .W     (FIFO_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_desc_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({enq_dest, enq_len}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State and beat-counter register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Next-state logic; the grant is only honoured while requesting.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = REQ;
      end
      REQ: begin
        if (tx_grant) begin
          fifo_pop = 1'b1;
          beat_d   = head_len;
          state_d  = XMIT;
        end
      end
      XMIT: begin
        if (beat_q == '0) state_d = fifo_empty ? IDLE : REQ;
        else              beat_d  = beat_q - LEN_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    req_d         = '0;
    xmit_active_d = 1'b0;
    xmit_last_d   = 1'b0;
    xmit_dest_d   = xmit_dest;
    drop_d        = enq_valid && !fifo_full && self_addr;
    if (fifo_pop) xmit_dest_d = head_dest;
    case (state_d)
      REQ:  req_d = {1'b1, head_dest};
      XMIT: begin
        xmit_active_d = 1'b1;
        xmit_last_d   = (beat_d == '0);
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      req_out     <= '0;
      xmit_active <= 1'b0;
      xmit_dest   <= '0;
      xmit_last   <= 1'b0;
      drop_err    <= 1'b0;
    end else begin
      req_out     <= req_d;
      xmit_active <= xmit_active_d;
      xmit_dest   <= xmit_dest_d;
      xmit_last   <= xmit_last_d;
      drop_err    <= drop_d;
    end
  end

endmodule
